game_ctrl: RTL and testbench

Game-flow controller that sits directly downstream of the ball motion block. Once per frame it samples the ball position and runs the IDLE/PLAY/OVER state machine. It scrolls the world when the ball climbs above a scroll line, and respawns three platforms at LFSR-random X positions as they leave the bottom of the screen. It also maintains score and high score. Its outputs feed the ball block (`scroll_delta`, `ball_reset`) and the colour mapper (`plat_x`, `plat_y`, score).

---
 rtl/game_pkg.sv | 11 +
 rtl/lfsr16.sv | 11 +
 rtl/game_ctrl.sv | 96 +++++++++
 tb/tb_game_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared states, screen geometry and initial platform layout for the game controller.
package game_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} game_state_t;
  localparam logic [10:0] Y_MAX = 11'd479;
  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [9:0] PLAT_W = 10'd80;
  localparam logic [7:0] START_KEY = 8'h2C;
  // Platform i occupies bits [10*i +: 10]
  localparam logic [29:0] INIT_X = {10'd317, 10'd165, 10'd240};
  localparam logic [29:0] INIT_Y = {10'd290, 10'd380, 10'd470};
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11), reloads SEED on reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] q
);
  always_ff @(posedge Clk)
    q <= Reset ? SEED : ({1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000));
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: per-frame game flow -- IDLE/PLAY/OVER FSM, world scroll, platform respawn and scoring.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [10:0] SCROLL_LINE = 11'd160,
  parameter logic [10:0] BALL_H      = 11'd10,
  parameter logic [9:0]  MAX_DELTA   = 10'd32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [7:0]  keycode,
  input  logic [10:0] BallY,
  output logic [1:0]  game_state,
  output logic        ball_reset,
  output logic [9:0]  scroll_delta,
  output logic        scroll_valid,
  output logic [29:0] plat_x,
  output logic [29:0] plat_y,
  output logic [15:0] score,
  output logic [15:0] hi_score
);
  game_state_t r_state, w_next;
  logic [7:0]  r_prev_key;
  logic [15:0] w_lfsr, r_score, r_hi;
  logic [9:0]  r_delta, w_d;
  logic [10:0] w_diff;
  logic [16:0] w_sum;
  logic        r_ball_reset, r_valid, w_start, w_go, w_over, w_scroll, w_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.Clk(Clk), .Reset(Reset), .q(w_lfsr));

  assign w_unused = ^w_lfsr[15:11];
  assign w_start  = (keycode == START_KEY) && (r_prev_key != START_KEY);
  assign w_go     = (r_state == IDLE) && w_start;
  // Ball below the floor only counts while it is on screen; above-screen values wrap past 1023
  assign w_over   = (r_state == PLAY) && frame_tick && !BallY[10] && (BallY + BALL_H >= Y_MAX);
  assign w_diff   = SCROLL_LINE - BallY;
  assign w_d      = BallY[10] ? MAX_DELTA :
                    (BallY < SCROLL_LINE) ? ((w_diff > {1'b0, MAX_DELTA}) ? MAX_DELTA : w_diff[9:0]) : 10'd0;
  assign w_scroll = (r_state == PLAY) && frame_tick && !w_over && (w_d != 10'd0);
  assign w_sum    = {1'b0, r_score} + {7'd0, w_d};

  always_comb begin
    w_next = w_go ? PLAY :
             w_over ? OVER :
             ((r_state == OVER) && w_start) ? IDLE : r_state;
  end

  always_ff @(posedge Clk)
    r_state <= Reset ? IDLE : w_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev_key   <= 8'd0;
      r_ball_reset <= 1'b0;
      r_valid      <= 1'b0;
      r_delta      <= 10'd0;
      r_score      <= 16'd0;
      r_hi         <= 16'd0;
    end else begin
      r_prev_key   <= keycode;
      r_ball_reset <= w_go;
      r_valid      <= w_scroll;
      if (w_scroll) r_delta <= w_d;
      if (w_go) r_score <= 16'd0;
      else if (w_scroll) r_score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      if (w_over && r_score > r_hi) r_hi <= r_score;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_plat
    logic [9:0]  r_x, r_y;
    logic [10:0] w_n;
    assign w_n = {1'b0, r_y} + {1'b0, w_d};
    always_ff @(posedge Clk) begin
      if (Reset || w_go) begin
        r_x <= INIT_X[10*i +: 10];
        r_y <= INIT_Y[10*i +: 10];
      end else if (w_scroll) begin
        r_y <= (w_n > Y_MAX) ? (w_n[9:0] - SCREEN_H) : w_n[9:0];
        if (w_n > Y_MAX) r_x <= {1'b0, w_lfsr[8+i:i]};
      end
    end
    assign plat_x[10*i +: 10] = r_x;
    assign plat_y[10*i +: 10] = r_y;
  end

  assign game_state   = r_state;
  assign ball_reset   = r_ball_reset;
  assign scroll_valid = r_valid;
  assign scroll_delta = r_delta;
  assign score        = r_score;
  assign hi_score     = r_hi;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed vector table plus random frames checked against a frame-level game model.
module tb_game_ctrl;
  logic        Clk = 1'b0, Reset, frame_tick, ball_reset, scroll_valid;
  logic [7:0]  keycode;
  logic [10:0] BallY;
  logic [1:0]  game_state;
  logic [9:0]  scroll_delta;
  logic [29:0] plat_x, plat_y;
  logic [15:0] score, hi_score;
  int checks = 0, errors = 0;
  int m_state, m_score, m_hi, m_sd, m_prev, e_br, e_sv;
  int m_px[3], m_py[3];
  logic [15:0] m_lfsr;

  typedef struct {
    bit rst; int key; int by; bit ft;
    int st; int br; int sv; int sd; int sc; int hi;
  } vec_t;
  vec_t v[22];

  game_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode), .BallY(BallY),
    .game_state(game_state), .ball_reset(ball_reset), .scroll_delta(scroll_delta),
    .scroll_valid(scroll_valid), .plat_x(plat_x), .plat_y(plat_y), .score(score), .hi_score(hi_score)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic init_plats();
    m_px = '{240, 165, 317};
    m_py = '{470, 380, 290};
  endtask

  // Frame-level rules of the game applied to the model for one clock edge
  task automatic model(input bit rst, input int key, input int by, input bit ft);
    bit se;
    int d, n;
    e_br = 0;
    e_sv = 0;
    if (rst) begin
      m_state = 0; m_score = 0; m_hi = 0; m_sd = 0; m_prev = 0;
      m_lfsr = 16'hACE1;
      init_plats();
      return;
    end
    se = (key == 8'h2C) && (m_prev != 8'h2C);
    if (m_state == 0 && se) begin
      m_state = 1; e_br = 1; m_score = 0;
      init_plats();
    end else if (m_state == 1 && ft) begin
      if (by < 1024 && by + 10 >= 479) begin
        m_state = 2;
        if (m_score > m_hi) m_hi = m_score;
      end else begin
        d = (by >= 1024) ? 32 : (by < 160) ? ((160 - by > 32) ? 32 : 160 - by) : 0;
        if (d > 0) begin
          e_sv = 1;
          m_sd = d;
          m_score = (m_score + d > 65535) ? 65535 : m_score + d;
          for (int i = 0; i < 3; i++) begin
            n = m_py[i] + d;
            if (n > 479) begin
              m_py[i] = n - 480;
              m_px[i] = int'((m_lfsr >> i) & 16'h01FF);
            end else m_py[i] = n;
          end
        end
      end
    end else if (m_state == 2 && se) m_state = 0;
    m_prev = key;
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic chk_all();
    chk("state", 32'(game_state), m_state);
    chk("ball_reset", 32'(ball_reset), e_br);
    chk("scroll_valid", 32'(scroll_valid), e_sv);
    chk("scroll_delta", 32'(scroll_delta), m_sd);
    chk("score", 32'(score), m_score);
    chk("hi_score", 32'(hi_score), m_hi);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("plat_x%0d", i), 32'(plat_x[10*i +: 10]), m_px[i]);
      chk($sformatf("plat_y%0d", i), 32'(plat_y[10*i +: 10]), m_py[i]);
    end
  endtask

  task automatic step(input bit rst, input int key, input int by, input bit ft);
    Reset = rst;
    keycode = 8'(key);
    BallY = 11'(by);
    frame_tick = ft;
    model(rst, key, by, ft);
    @(posedge Clk);
    #1;
    chk_all();
  endtask

  initial begin
    int by, key;
    //        rst key    by    ft  st br sv sd  score hi
    v[0]  = '{1, 0,      0,    0,  0, 0, 0, 0,  0,    0};
    v[1]  = '{1, 0,      0,    0,  0, 0, 0, 0,  0,    0};
    v[2]  = '{0, 8'h2C,  300,  0,  1, 1, 0, 0,  0,    0};
    v[3]  = '{0, 0,      300,  0,  1, 0, 0, 0,  0,    0};
    v[4]  = '{0, 0,      140,  1,  1, 0, 1, 20, 20,   0};
    v[5]  = '{0, 0,      140,  0,  1, 0, 0, 20, 20,   0};
    v[6]  = '{0, 0,      1030, 1,  1, 0, 1, 32, 52,   0};
    v[7]  = '{0, 0,      300,  1,  1, 0, 0, 32, 52,   0};
    v[8]  = '{0, 0,      160,  1,  1, 0, 0, 32, 52,   0};
    v[9]  = '{0, 0,      159,  1,  1, 0, 1, 1,  53,   0};
    v[10] = '{0, 0,      128,  1,  1, 0, 1, 32, 85,   0};
    v[11] = '{0, 0,      127,  1,  1, 0, 1, 32, 117,  0};
    v[12] = '{0, 0,      468,  1,  1, 0, 0, 32, 117,  0};
    v[13] = '{0, 0,      469,  1,  2, 0, 0, 32, 117,  117};
    v[14] = '{0, 0,      140,  1,  2, 0, 0, 32, 117,  117};
    v[15] = '{0, 8'h2C,  140,  0,  0, 0, 0, 32, 117,  117};
    v[16] = '{0, 8'h2C,  140,  0,  0, 0, 0, 32, 117,  117};
    v[17] = '{0, 8'h2C,  140,  1,  0, 0, 0, 32, 117,  117};
    v[18] = '{0, 0,      140,  0,  0, 0, 0, 32, 117,  117};
    v[19] = '{0, 8'h2C,  140,  1,  1, 1, 0, 32, 0,    117};
    v[20] = '{0, 0,      100,  1,  1, 0, 1, 32, 32,   117};
    v[21] = '{0, 0,      470,  1,  2, 0, 0, 32, 32,   117};
    for (int i = 0; i < 22; i++) begin
      step(v[i].rst, v[i].key, v[i].by, v[i].ft);
      chk($sformatf("vec%0d_state", i), 32'(game_state), v[i].st);
      chk($sformatf("vec%0d_ball_reset", i), 32'(ball_reset), v[i].br);
      chk($sformatf("vec%0d_valid", i), 32'(scroll_valid), v[i].sv);
      chk($sformatf("vec%0d_delta", i), 32'(scroll_delta), v[i].sd);
      chk($sformatf("vec%0d_score", i), 32'(score), v[i].sc);
      chk($sformatf("vec%0d_hi", i), 32'(hi_score), v[i].hi);
      if (i == 4) begin
        chk("wrap_y0", 32'(plat_y[9:0]), 10);
        chk("wrap_y1", 32'(plat_y[19:10]), 400);
        chk("wrap_y2", 32'(plat_y[29:20]), 310);
        chk("keep_x1", 32'(plat_x[19:10]), 165);
        chk("keep_x2", 32'(plat_x[29:20]), 317);
      end
    end
    // Restart and push the score into saturation
    step(0, 8'h2C, 300, 0);
    step(0, 0, 300, 0);
    step(0, 8'h2C, 300, 0);
    step(0, 0, 300, 0);
    chk("restart_state", 32'(game_state), 1);
    for (int i = 0; i < 2047; i++) step(0, 0, 2000, 1);
    step(0, 0, 144, 1);
    chk("score_fff0", 32'(score), 16'hFFF0);
    step(0, 0, 1500, 1);
    chk("score_sat", 32'(score), 16'hFFFF);
    step(0, 0, 1500, 1);
    chk("score_sat_hold", 32'(score), 16'hFFFF);
    // Reset in the middle of play
    step(1, 0, 1500, 1);
    chk("rst_state", 32'(game_state), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_hi", 32'(hi_score), 0);
    chk("rst_delta", 32'(scroll_delta), 0);
    chk("rst_valid", 32'(scroll_valid), 0);
    chk("rst_plat_y", 32'(plat_y), {10'd290, 10'd380, 10'd470});
    chk("rst_plat_x", 32'(plat_x), {10'd317, 10'd165, 10'd240});
    step(0, 0, 300, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: by = int'($urandom_range(1024, 2047));
        1: by = int'($urandom_range(0, 159));
        2: by = int'($urandom_range(160, 468));
        default: by = int'($urandom_range(469, 1023));
      endcase
      key = ($urandom_range(0, 3) == 0) ? 8'h2C : int'($urandom_range(0, 255));
      step($urandom_range(0, 199) == 0, key, by, $urandom_range(0, 1) == 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
